// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states
// and the iteration counter width helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the CPU control path and the HI/LO unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_wr, lo_wr, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_wr, lo_wr, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit_sign_mag_conv.sv
// Conditional two's-complement negate: yields |x| from a negative operand,
// or re-applies a sign to a magnitude.
module sign_mag_conv #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);
  assign out_o = neg_i ? (~in_i + W'(1)) : in_i;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; one bit per cycle over
// operand magnitudes, with the sign fix-up and HI/LO write in a final FIX step.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int CW = cnt_width(WIDTH);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 is_div_q, is_div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;

  logic                 sa_in, sb_in, dz_in;
  logic [WIDTH-1:0]     mag_a, mag_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH:0]       mul_sum, rem_shift, div_diff;

  // Signs only matter for the signed opcodes (op[0]==0).
  assign sa_in = ~bus.op[0] & bus.a[WIDTH-1];
  assign sb_in = ~bus.op[0] & bus.b[WIDTH-1];
  assign dz_in = bus.op[1] & (bus.b == '0);

  sign_mag_conv #(.W(WIDTH))   u_mag_a    (.in_i(bus.a), .neg_i(sa_in), .out_o(mag_a));
  sign_mag_conv #(.W(WIDTH))   u_mag_b    (.in_i(bus.b), .neg_i(sb_in), .out_o(mag_b));
  sign_mag_conv #(.W(2*WIDTH)) u_fix_prod (.in_i(acc_q), .neg_i(sa_q ^ sb_q), .out_o(prod_fix));
  sign_mag_conv #(.W(WIDTH))   u_fix_quo  (.in_i(acc_q[WIDTH-1:0]), .neg_i(sa_q ^ sb_q), .out_o(quo_fix));
  sign_mag_conv #(.W(WIDTH))   u_fix_rem  (.in_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sa_q), .out_o(rem_fix));

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = rem_shift - {1'b0, opnd_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          sa_d     = sa_in;
          sb_d     = sb_in;
          dz_d     = dz_in;
          cnt_d    = CW'(WIDTH);
          opnd_d   = bus.op[1] ? mag_b : mag_a;
          acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
          state_d  = dz_in ? S_DONE : S_RUN;
        end else begin
          if (bus.hi_wr) hi_d = bus.wdata;
          if (bus.lo_wr) lo_d = bus.wdata;
        end
      end
      S_RUN: begin
        if (!is_div_q)
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        else if (div_diff[WIDTH])
          acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.done     = (state_q == S_DONE);
  assign bus.div_zero = (state_q == S_DONE) && dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [W-1:0] mh = '0;
  logic [W-1:0] ml = '0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input op_e o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi_o, output logic [W-1:0] lo_o,
                                output logic dz);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    dz = 1'b0; hi_o = mh; lo_o = ml;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  begin sp = sa * sb; hi_o = sp[63:32]; lo_o = sp[31:0]; end
      OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; hi_o = up[63:32]; lo_o = up[31:0]; end
      OP_DIV: begin
        if (b == 0) dz = 1'b1;
        else begin sq = sa / sb; sr = sa % sb; lo_o = sq[31:0]; hi_o = sr[31:0]; end
      end
      default: begin
        if (b == 0) dz = 1'b1;
        else begin lo_o = a / b; hi_o = a % b; end
      end
    endcase
  endfunction

  // One operation; optionally pokes start(DIV)+hi_wr mid-run, which must be ignored.
  task automatic do_op(input op_e o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit interfere, input string tag);
    logic [W-1:0] eh, el;
    logic edz;
    int edges;
    bit busy_ok;
    model(o, av, bv, eh, el, edz);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    edges = 0; busy_ok = 1'b1;
    while (!bus.done && edges < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (interfere && edges == 9) begin
        bus.start = 1'b1; bus.op = OP_DIV; bus.hi_wr = 1'b1; bus.wdata = $urandom;
      end
      if (interfere && edges == 10) begin
        bus.start = 1'b0; bus.hi_wr = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_latency"}, 64'(edges), edz ? 64'd0 : 64'(W + 1));
    chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
    chk({tag, "_dz"}, 64'(bus.div_zero), 64'(edz));
    $display("%s op=%0d a=%h b=%h hi=%h lo=%h dz=%0d lat=%0d", tag, o, av, bv,
             bus.hi, bus.lo, bus.div_zero, edges);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    mh = eh; ml = el;
  endtask

  task automatic write_hilo(input logic [W-1:0] hv, input logic [W-1:0] lv);
    @(negedge clk);
    bus.hi_wr = 1'b1; bus.lo_wr = 1'b1; bus.wdata = hv;
    @(negedge clk);
    bus.hi_wr = 1'b0; bus.wdata = lv;
    @(negedge clk);
    bus.lo_wr = 1'b0;
    mh = hv; ml = lv;
    chk("mthi", 64'(bus.hi), 64'(hv));
    chk("mtlo", 64'(bus.lo), 64'(lv));
  endtask

  initial begin
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    int dcount;
    bus.start = 1'b0; bus.op = OP_MULT; bus.a = '0; bus.b = '0;
    bus.hi_wr = 1'b0; bus.lo_wr = 1'b0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    @(negedge clk); reset = 1'b0;

    do_op(OP_MULT,  32'hFFFFFFFD, 32'h00000005, 1'b0, "t1_mult");
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "t2_multu");
    do_op(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "t2_mult");
    do_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, "t3_div");
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, "t3_ovf");
    write_hilo(32'h1234, 32'h5678);
    do_op(OP_DIVU,  32'h00000007, 32'h00000000, 1'b0, "t4_dz");
    do_op(OP_MULT,  32'h00012345, 32'hFFFF0F0F, 1'b1, "t5_ignore");

    // Abort a DIV mid-run with reset: HI/LO clear, no done pulse follows.
    write_hilo(32'hA5A5A5A5, 32'h5A5A5A5A);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_hi", 64'(bus.hi), 64'd0);
    chk("t6_lo", 64'(bus.lo), 64'd0);
    mh = '0; ml = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dcount++;
    end
    chk("t6_no_done", 64'(dcount), 64'd0);
    do_op(OP_MULTU, 32'd6, 32'd7, 1'b0, "t6_multu");

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      do_op(op_e'(rop), ra, rb, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
